// File: rtl/alu_op_sequencer.sv
// Initiator-side sequencer for the ALU microcode interface: B-port write, bus turnaround,
// timed runit execution, result capture from IBUS and L/V flag tracking.
module alu_op_sequencer #(
    parameter int ADD_CYCLES = 2,
    parameter int OP_CYCLES  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [2:0]  req_roll,
    input  logic        req_loadb,
    input  logic [15:0] req_operand,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_l,
    output logic        rsp_v,
    output logic        rsp_err,
    output logic [3:0]  runit,
    output logic [2:0]  ir_roll,
    output logic [15:0] ibus_out,
    output logic        ibus_oe,
    input  logic [15:0] ibus_in,
    output logic        nwalu,
    output logic        fl,
    input  logic        nflstrobe,
    input  logic        fv,
    input  logic        nfltadd
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOADB = 3'd1;
    localparam logic [2:0] S_TURN  = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_ROLL = 4'b1100;

    localparam int ADD_N = (ADD_CYCLES < 1) ? 1 : ADD_CYCLES;
    localparam int OP_N  = (OP_CYCLES < 1) ? 1 : OP_CYCLES;
    localparam int MAX_N = (ADD_N > OP_N) ? ADD_N : OP_N;
    localparam int CW    = ($clog2(MAX_N + 1) < 2) ? 2 : $clog2(MAX_N + 1);

    logic [2:0]    state_q, state_d;
    logic [3:0]    op_q, op_d;
    logic [2:0]    roll_q, roll_d;
    logic [15:0]   operand_q, operand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          l_q, l_d, v_q, v_d, toggled_q, toggled_d;
    logic [15:0]   result_q, result_d;
    logic          rsp_l_q, rsp_l_d, rsp_v_q, rsp_v_d, err_q, err_d;

    // Counter preload is length-1 so that cnt==0 marks the final EXEC cycle.
    function automatic logic [CW-1:0] exec_len(input logic [3:0] op);
        return (op == OP_ADD) ? CW'(ADD_N - 1) : CW'(OP_N - 1);
    endfunction

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        roll_d    = roll_q;
        operand_d = operand_q;
        cnt_d     = cnt_q;
        l_d       = l_q;
        v_d       = v_q;
        toggled_d = toggled_q;
        result_d  = result_q;
        rsp_l_d   = rsp_l_q;
        rsp_v_d   = rsp_v_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d      = req_op;
                    roll_d    = req_roll;
                    operand_d = req_operand;
                    if (!req_op[3]) begin
                        state_d  = S_DONE;
                        err_d    = 1'b1;
                        result_d = 16'h0000;
                        rsp_l_d  = l_q;
                        rsp_v_d  = v_q;
                    end else begin
                        err_d = 1'b0;
                        if (req_loadb) begin
                            state_d = S_LOADB;
                        end else begin
                            state_d   = S_EXEC;
                            cnt_d     = exec_len(req_op);
                            toggled_d = 1'b0;
                        end
                    end
                end
            end
            S_LOADB: state_d = S_TURN;
            S_TURN: begin
                state_d   = S_EXEC;
                cnt_d     = exec_len(op_q);
                toggled_d = 1'b0;
            end
            S_EXEC: begin
                // Carry may be flagged on several cycles of a multi-cycle add; toggle L only once.
                if (!nfltadd && !toggled_q) begin
                    l_d       = ~l_q;
                    toggled_d = 1'b1;
                end
                if (!nflstrobe) v_d = fv;
                if (cnt_q == '0) begin
                    state_d  = S_DONE;
                    result_d = ibus_in;
                    rsp_l_d  = l_d;
                    rsp_v_d  = v_d;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= 4'h0;
            roll_q    <= 3'h0;
            operand_q <= 16'h0000;
            cnt_q     <= '0;
            l_q       <= 1'b0;
            v_q       <= 1'b0;
            toggled_q <= 1'b0;
            result_q  <= 16'h0000;
            rsp_l_q   <= 1'b0;
            rsp_v_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            roll_q    <= roll_d;
            operand_q <= operand_d;
            cnt_q     <= cnt_d;
            l_q       <= l_d;
            v_q       <= v_d;
            toggled_q <= toggled_d;
            result_q  <= result_d;
            rsp_l_q   <= rsp_l_d;
            rsp_v_q   <= rsp_v_d;
            err_q     <= err_d;
        end
    end

    // Bus-side outputs decode straight from state so reset releases them immediately.
    assign req_ready  = (state_q == S_IDLE) && !reset;
    assign rsp_valid  = (state_q == S_DONE);
    assign rsp_result = result_q;
    assign rsp_l      = rsp_l_q;
    assign rsp_v      = rsp_v_q;
    assign rsp_err    = err_q;
    assign runit      = (state_q == S_EXEC) ? op_q : 4'h0;
    assign ir_roll    = (state_q == S_EXEC && op_q == OP_ROLL) ? roll_q : 3'h0;
    assign ibus_oe    = (state_q == S_LOADB);
    assign ibus_out   = (state_q == S_LOADB) ? operand_q : 16'h0000;
    assign nwalu      = (state_q != S_LOADB);
    assign fl         = l_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small behavioural ALU on IBUS.
module tb_alu_op_sequencer;
    logic        clk = 1'b0, reset = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_loadb = 1'b0;
    logic [3:0]  req_op = 4'h0;
    logic [2:0]  req_roll = 3'h0;
    logic [15:0] req_operand = 16'h0;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [15:0] rsp_result;
    logic        rsp_l, rsp_v, rsp_err;
    logic [3:0]  runit;
    logic [2:0]  ir_roll;
    logic [15:0] ibus_out, ibus_in;
    logic        ibus_oe, nwalu, fl, nflstrobe, fv, nfltadd;

    int n_vec = 0, n_bad = 0;

    alu_op_sequencer #(.ADD_CYCLES(2), .OP_CYCLES(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_roll(req_roll),
        .req_loadb(req_loadb), .req_operand(req_operand),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_l(rsp_l), .rsp_v(rsp_v), .rsp_err(rsp_err),
        .runit(runit), .ir_roll(ir_roll), .ibus_out(ibus_out), .ibus_oe(ibus_oe),
        .ibus_in(ibus_in), .nwalu(nwalu), .fl(fl),
        .nflstrobe(nflstrobe), .fv(fv), .nfltadd(nfltadd)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: AND=1001, OR=1010, XOR=1011, ADD=1000 (no carry-in), others pass AC.
    logic [15:0] ac = 16'h0, b_reg = 16'h0, alu_res;
    logic [16:0] sum;
    always_comb begin
        sum = {1'b0, ac} + {1'b0, b_reg};
        case (runit)
            4'b1000: alu_res = sum[15:0];
            4'b1001: alu_res = ac & b_reg;
            4'b1010: alu_res = ac | b_reg;
            4'b1011: alu_res = ac ^ b_reg;
            default: alu_res = ac;
        endcase
    end
    assign ibus_in   = ibus_oe ? ibus_out : ((runit != 4'h0) ? alu_res : 16'h0);
    assign nfltadd   = !(runit == 4'b1000 && sum[16]);
    assign nflstrobe = !(runit == 4'b1000);
    assign fv        = (ac[15] == b_reg[15]) && (sum[15] != ac[15]);
    always @(posedge clk) if (!nwalu) b_reg <= ibus_in;

    // Bus activity monitor: running totals, callers take differences.
    int nw_cnt = 0, oe_cnt = 0, add_cnt = 0, run_cnt = 0, roll_bad = 0, roll_cyc = 0;
    logic [15:0] nw_bus = 16'h0;
    logic        prev_nw = 1'b1, turn_oe = 1'b1;
    logic [3:0]  turn_runit = 4'hF;
    logic [2:0]  exp_roll = 3'h0;
    always @(negedge clk) begin
        if (!nwalu) begin nw_cnt++; nw_bus = ibus_out; end
        if (ibus_oe) oe_cnt++;
        if (runit == 4'b1000) add_cnt++;
        if (runit != 4'h0) run_cnt++;
        if (runit == 4'b1100) begin
            roll_cyc++;
            if (ir_roll != exp_roll) roll_bad++;
        end else if (ir_roll != 3'h0) roll_bad++;
        if (!prev_nw && nwalu) begin turn_oe = ibus_oe; turn_runit = runit; end
        prev_nw = nwalu;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic [3:0] op, input logic [2:0] roll,
                         input logic loadb, input logic [15:0] operand,
                         input logic [15:0] e_res, input logic e_l, input logic e_v,
                         input logic e_err, input int e_lat, input int hold);
        int lat = 0;
        @(negedge clk);
        chk({tag, ".ready"}, req_ready, 1'b1);
        req_valid = 1'b1; req_op = op; req_roll = roll; req_loadb = loadb; req_operand = operand;
        @(posedge clk); #1;
        req_valid = 1'b0;
        while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        chk({tag, ".lat"}, lat, e_lat);
        chk({tag, ".res"}, rsp_result, e_res);
        chk({tag, ".l"}, rsp_l, e_l);
        chk({tag, ".v"}, rsp_v, e_v);
        chk({tag, ".err"}, rsp_err, e_err);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, ".hold_vld"}, rsp_valid, 1'b1);
            chk({tag, ".hold_rdy"}, req_ready, 1'b0);
            chk({tag, ".hold_res"}, rsp_result, e_res);
            chk({tag, ".hold_l"}, rsp_l, e_l);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, ".vld_drop"}, rsp_valid, 1'b0);
    endtask

    int nw0, oe0, add0, run0;

    initial begin
        #1;
        chk("rst.runit", runit, 4'h0);
        chk("rst.oe", ibus_oe, 1'b0);
        chk("rst.nwalu", nwalu, 1'b1);
        chk("rst.fl", fl, 1'b0);
        chk("rst.vld", rsp_valid, 1'b0);
        chk("rst.res", rsp_result, 16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        #1 chk("rst.ready", req_ready, 1'b1);

        // 1: ADD with B write; carry toggles L once across two EXEC cycles
        ac = 16'h9999; nw0 = nw_cnt; oe0 = oe_cnt; add0 = add_cnt;
        do_op("add1", 4'b1000, 3'h0, 1'b1, 16'hFFFF, 16'h9998, 1'b1, 1'b0, 1'b0, 4, 0);
        chk("add1.nw_cyc", nw_cnt - nw0, 1);
        chk("add1.nw_bus", nw_bus, 16'hFFFF);
        chk("add1.oe_cyc", oe_cnt - oe0, 1);
        chk("add1.run_cyc", add_cnt - add0, 2);
        chk("add1.turn_oe", turn_oe, 1'b0);
        chk("add1.turn_runit", turn_runit, 4'h0);
        chk("add1.fl", fl, 1'b1);

        // 2: ADD without carry keeps L=1
        ac = 16'h1234;
        do_op("add2", 4'b1000, 3'h0, 1'b1, 16'h1111, 16'h2345, 1'b1, 1'b0, 1'b0, 4, 0);

        // 3: logic ops back to back, B untouched
        nw0 = nw_cnt; run0 = run_cnt;
        do_op("and", 4'b1001, 3'h0, 1'b0, 16'hAAAA, 16'h1010, 1'b1, 1'b0, 1'b0, 1, 0);
        do_op("or",  4'b1010, 3'h0, 1'b0, 16'hAAAA, 16'h1335, 1'b1, 1'b0, 1'b0, 1, 0);
        do_op("xor", 4'b1011, 3'h0, 1'b0, 16'hAAAA, 16'h0325, 1'b1, 1'b0, 1'b0, 1, 0);
        chk("logic.nw_cyc", nw_cnt - nw0, 0);
        chk("logic.run_cyc", run_cnt - run0, 3);

        // 4: roll modes appear on ir_roll only during ROLL execution
        run0 = roll_cyc;
        exp_roll = 3'b011;
        do_op("rbr", 4'b1100, 3'b011, 1'b0, 16'h0, 16'h1234, 1'b1, 1'b0, 1'b0, 1, 0);
        exp_roll = 3'b110;
        do_op("rnl", 4'b1100, 3'b110, 1'b0, 16'h0, 16'h1234, 1'b1, 1'b0, 1'b0, 1, 0);
        chk("roll.cyc", roll_cyc - run0, 2);
        chk("roll.bad", roll_bad, 0);

        // 5: op[3]=0 is rejected without touching the ALU
        nw0 = nw_cnt; run0 = run_cnt;
        do_op("err", 4'b0101, 3'h0, 1'b1, 16'h5555, 16'h0000, 1'b1, 1'b0, 1'b1, 0, 0);
        chk("err.nw_cyc", nw_cnt - nw0, 0);
        chk("err.run_cyc", run_cnt - run0, 0);

        // overflow sets V so the reset below has something to clear
        ac = 16'h7000;
        do_op("ovf", 4'b1000, 3'h0, 1'b1, 16'h1000, 16'h8000, 1'b1, 1'b1, 1'b0, 4, 0);

        // 6: reset mid-EXEC
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'b1000; req_loadb = 1'b1; req_operand = 16'h0001;
        @(posedge clk); #1 req_valid = 1'b0;
        for (int i = 0; i < 10 && runit == 4'h0; i++) begin @(posedge clk); #1; end
        chk("mid.runit_pre", runit, 4'b1000);
        reset = 1'b1; #1;
        chk("mid.runit", runit, 4'h0);
        chk("mid.oe", ibus_oe, 1'b0);
        chk("mid.nwalu", nwalu, 1'b1);
        chk("mid.fl", fl, 1'b0);
        chk("mid.vld", rsp_valid, 1'b0);
        @(negedge clk); reset = 1'b0;
        ac = 16'h1234;
        do_op("hold", 4'b1001, 3'h0, 1'b1, 16'h00FF, 16'h0034, 1'b0, 1'b0, 1'b0, 3, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
